out_reg_shift_align: RTL and testbench
======================================

# out_reg_shift_align

Multi-channel output alignment stage for the systolic array: it takes CH row outputs per cycle and delays each one so that results from a partially used array (fewer than N active columns) and from skewed rows leave the block on the same cycle. It adds a valid pipeline, a stall input, a tile counter with a last/done indication, and a configuration register that can only be loaded while the block is idle. It sits between the PE array outputs and the output buffer writer.

## Interface
- I_WIDTH, 8, integer bits of each sample
- F_WIDTH, 8, fractional bits of each sample; W = I_WIDTH+F_WIDTH
- N, 4, maximum number of active columns (N ≥ 1)
- CH, 4, number of channels (array rows, CH ≥ 1)
- NUM_COL_WIDTH, $clog2(N+1), width of the column count (must represent N)
- CNT_WIDTH, 16, width of the tile length and counters
- clk_i  in  1  clock; all logic is on its rising edge
- out_reg_shift_rst_i  in  1  asynchronous, active-high reset
- in_data_i  in  CH*W  signed samples; channel c occupies bits [c*W +: W]
- in_valid_i  in  1  channel-0 sample valid
- in_ready_o  out  1  input accepted this cycle when high
- en_i  in  1  global advance; low stalls the block
- cfg_cols_i  in  NUM_COL_WIDTH  number of active columns
- cfg_skew_en_i  in  1  enables per-row deskew
- cfg_ld_i  in  1  load cfg_cols_i and cfg_skew_en_i
- tile_len_i  in  CNT_WIDTH  valid beats per tile, sampled at tile start
- number_of_columns_o  out  NUM_COL_WIDTH  current column configuration
- out_data_o  out  CH*W  aligned samples
- out_valid_o  out  1  aligned beat valid
- out_last_o  out  1  final beat of the tile
- busy_o  out  1  high whenever state ≠ IDLE
- done_o  out  1  one-cycle pulse when a tile completes

## Operation
- **Configuration:** cfg_ld_i is accepted only in IDLE and is ignored otherwise.
  - cfg_cols_i = 0 or > N loads N.
  - An accepted load also clears the valid pipeline. Data registers are not cleared.
- **Per-channel delay:** D_c = (N − cols) + (skew ? CH−1−c : 0). DMAX = N−1+CH−1.
- **Delay line:** each channel has its own shift line of depth DMAX.
  - When D_c = 0, out_data_o for that channel is combinational pass-through of in_data_i.
  - Otherwise it is the tap at stage D_c−1.
- **Valid pipeline:** a 1-bit pipeline of depth DMAX is fed with in_valid_i & in_ready_o.
  - out_valid_o is the tap at D_0, or the combinational input when D_0 = 0.
- **Stall:** when en_i = 0, all data, valid and counter registers hold. in_ready_o = 0, out_valid_o = 0, done_o = 0.
- **Ready:** in_ready_o = en_i & (state ≠ DRAIN).
- **FSM:**
  - IDLE: captures tile length L = max(tile_len_i, 1) on the first accepted beat, sets in_cnt = 1 and goes to RUN. If L = 1, it goes straight to DRAIN.
  - RUN: each accepted beat increments in_cnt. When in_cnt reaches L, go to DRAIN.
  - DRAIN: input is not accepted.
  - out_cnt counts beats where out_valid_o & en_i in RUN or DRAIN.
  - out_last_o = out_valid_o & en_i & (out_cnt == L−1).
  - The cycle after the last beat: done_o = 1, then return to IDLE and clear both counters.
- **Data:** signed samples pass through unmodified, with no arithmetic or saturation.

## Timing
- **Reset values:**
  - All shift registers and valid stages are 0; state is IDLE.
  - number_of_columns_o = N; out_valid_o, out_last_o, busy_o and done_o are 0.
  - in_ready_o = 0 while the reset is asserted.
  - out_data_o shows in_data_i, because D_c = 0 when cols = N and skew is 0.
- **Latency:** channel c output lags its input by D_c enabled cycles. Stalled cycles do not count.
- **Deskew example:** with N = 4, CH = 4, cols = 2 and skew on, D = {5, 4, 3, 2}. A skewed wavefront is realigned and out_valid_o follows in_valid_i by 5 cycles.
- **Config load timing:** a new config takes effect on the cycle after cfg_ld_i.
- **cfg_ld_i with a beat in IDLE:** the beat is accepted and the tile starts, and the config load still applies because the FSM was in IDLE.
- **Reset mid-tile:** clears everything immediately; no done_o is produced.
- **done_o and a new tile:** done_o and a new tile start never coincide, because there is one IDLE cycle minimum.

## Test plan
- Reset asserted mid-DRAIN → same cycle: busy_o = 0, out_valid_o = 0, number_of_columns_o = 4.
- N = 4, CH = 4, cols = 4, skew = 0, L = 3, ch0 inputs 10, 11, 12 → outputs on the same cycle; out_last_o on 12; done_o one cycle later.
- cols = 2, skew = 1, channel c sample 100+c injected at cycle c → all four emerge together at cycle 5; out_valid_o is high once.
- L = 4 with en_i low for 2 cycles mid-drain → outputs hold; out_last_o is delayed by exactly 2 cycles; out_cnt = 4.
- cfg_ld_i with cols = 3 while busy → number_of_columns_o is unchanged. Load in IDLE with cols = 0 → number_of_columns_o = 4.
- tile_len_i = 0 → treated as 1: one beat in, out_last_o on that beat, done_o next cycle; in_ready_o = 0 during DRAIN.

Source files
------------

// File: rtl/out_reg_shift_align.sv
// Output alignment stage: per-channel delay lines that equalize column fill and row skew,
// plus a valid pipeline, stall, tile counting and an idle-only configuration register.
module out_reg_shift_align_lane #(
  parameter int W    = 16,
  parameter int DMAX = 6,
  parameter int DW   = 3
) (
  input  logic          clk_i,
  input  logic          out_reg_shift_rst_i,
  input  logic          en,
  input  logic [W-1:0]  din,
  input  logic [DW-1:0] tap,
  output logic [W-1:0]  dout
);
  localparam int SD = (DMAX > 0) ? DMAX : 1;

  logic [SD-1:0][W-1:0] sr;
  logic [DMAX:0][W-1:0] taps;

  always_ff @(posedge clk_i or posedge out_reg_shift_rst_i) begin
    if (out_reg_shift_rst_i) begin
      sr <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int k = 1; k < SD; k++) sr[k] <= sr[k-1];
    end
  end

  // Tap 0 is the live input so a zero delay is a pure pass-through.
  always_comb begin
    taps[0] = din;
    for (int k = 1; k <= DMAX; k++) taps[k] = sr[k-1];
  end

  assign dout = taps[tap];
endmodule

module out_reg_shift_align #(
  parameter int I_WIDTH       = 8,
  parameter int F_WIDTH       = 8,
  parameter int N             = 4,
  parameter int CH            = 4,
  parameter int NUM_COL_WIDTH = $clog2(N+1),
  parameter int CNT_WIDTH     = 16
) (
  input  logic                      clk_i,
  input  logic                      out_reg_shift_rst_i,
  input  logic [CH*(I_WIDTH+F_WIDTH)-1:0] in_data_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      en_i,
  input  logic [NUM_COL_WIDTH-1:0]  cfg_cols_i,
  input  logic                      cfg_skew_en_i,
  input  logic                      cfg_ld_i,
  input  logic [CNT_WIDTH-1:0]      tile_len_i,
  output logic [NUM_COL_WIDTH-1:0]  number_of_columns_o,
  output logic [CH*(I_WIDTH+F_WIDTH)-1:0] out_data_o,
  output logic                      out_valid_o,
  output logic                      out_last_o,
  output logic                      busy_o,
  output logic                      done_o
);
  localparam int W    = I_WIDTH + F_WIDTH;
  localparam int DMAX = N + CH - 2;
  localparam int DW   = (DMAX > 0) ? $clog2(DMAX+1) : 1;
  localparam int SD   = (DMAX > 0) ? DMAX : 1;
  localparam logic [NUM_COL_WIDTH-1:0] NMAX = NUM_COL_WIDTH'(N);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [NUM_COL_WIDTH-1:0] cols_q;
  logic                     skew_q;
  logic [CH-1:0][DW-1:0]    dly;
  logic                     acc, cfg_acc;
  logic [SD-1:0]            vld_sr;
  logic [DMAX:0]            vld_pipe;
  logic [CNT_WIDTH-1:0]     in_cnt_q, out_cnt_q, tile_len_q, tl_in, l_cur;

  assign in_ready_o = en_i & ~out_reg_shift_rst_i & (state_q != DRAIN) & (state_q != DONE);
  assign acc        = in_valid_i & in_ready_o;
  assign cfg_acc    = cfg_ld_i & (state_q == IDLE);
  assign number_of_columns_o = cols_q;

  always_ff @(posedge clk_i or posedge out_reg_shift_rst_i) begin
    if (out_reg_shift_rst_i) begin
      cols_q <= NMAX;
      skew_q <= 1'b0;
    end else if (cfg_acc) begin
      cols_q <= (cfg_cols_i == '0 || cfg_cols_i > NMAX) ? NMAX : cfg_cols_i;
      skew_q <= cfg_skew_en_i;
    end
  end

  // Short tiles wait (N-cols) beats; skewed row c is early by CH-1-c beats.
  always_comb begin
    for (int c = 0; c < CH; c++)
      dly[c] = DW'(N - int'(cols_q) + (skew_q ? (CH - 1 - c) : 0));
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    out_reg_shift_align_lane #(.W(W), .DMAX(DMAX), .DW(DW)) u_lane (
      .clk_i               (clk_i),
      .out_reg_shift_rst_i (out_reg_shift_rst_i),
      .en                  (en_i),
      .din                 (in_data_i[c*W +: W]),
      .tap                 (dly[c]),
      .dout                (out_data_o[c*W +: W])
    );
  end

  // A config load flushes stale valids but keeps a beat accepted in the same cycle.
  always_ff @(posedge clk_i or posedge out_reg_shift_rst_i) begin
    if (out_reg_shift_rst_i) begin
      vld_sr <= '0;
    end else if (cfg_acc) begin
      vld_sr <= '0;
      if (en_i) vld_sr[0] <= acc;
    end else if (en_i) begin
      vld_sr[0] <= acc;
      for (int k = 1; k < SD; k++) vld_sr[k] <= vld_sr[k-1];
    end
  end

  always_comb begin
    vld_pipe[0] = acc;
    for (int k = 1; k <= DMAX; k++) vld_pipe[k] = vld_sr[k-1];
  end

  assign tl_in = (tile_len_i == '0) ? CNT_WIDTH'(1) : tile_len_i;
  assign l_cur = (state_q == IDLE) ? tl_in : tile_len_q;

  always_ff @(posedge clk_i or posedge out_reg_shift_rst_i) begin
    if (out_reg_shift_rst_i) state_q <= IDLE;
    else                     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acc) state_d = (tl_in == CNT_WIDTH'(1)) ? DRAIN : RUN;
      RUN:     if (acc && (in_cnt_q + 1'b1) == tile_len_q) state_d = DRAIN;
      DONE:    if (en_i) state_d = IDLE;
      default: state_d = state_q;
    endcase
    if (out_last_o) state_d = DONE;
  end

  always_comb begin
    out_valid_o = vld_pipe[dly[0]] & en_i;
    out_last_o  = out_valid_o & (out_cnt_q == l_cur - 1'b1);
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE) & en_i;
  end

  always_ff @(posedge clk_i or posedge out_reg_shift_rst_i) begin
    if (out_reg_shift_rst_i) begin
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      tile_len_q <= '0;
    end else if (en_i) begin
      if (state_q == DONE) begin
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (acc)         in_cnt_q  <= in_cnt_q + 1'b1;
        if (out_valid_o) out_cnt_q <= out_cnt_q + 1'b1;
      end
      if (state_q == IDLE && acc) tile_len_q <= tl_in;
    end
  end
endmodule

// File: tb/tb_out_reg_shift_align.sv
// Directed bench for out_reg_shift_align with N=4, CH=4, W=16.
module tb_out_reg_shift_align;
  localparam int W  = 16;
  localparam int CH = 4;

  logic            clk_i = 1'b0;
  logic            out_reg_shift_rst_i;
  logic [CH*W-1:0] in_data_i;
  logic            in_valid_i, in_ready_o, en_i;
  logic [2:0]      cfg_cols_i;
  logic            cfg_skew_en_i, cfg_ld_i;
  logic [15:0]     tile_len_i;
  logic [2:0]      number_of_columns_o;
  logic [CH*W-1:0] out_data_o;
  logic            out_valid_o, out_last_o, busy_o, done_o;

  int n_cmp = 0;
  int n_err = 0;

  out_reg_shift_align #(.I_WIDTH(8), .F_WIDTH(8), .N(4), .CH(4), .CNT_WIDTH(16)) dut (
    .clk_i(clk_i), .out_reg_shift_rst_i(out_reg_shift_rst_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .en_i(en_i),
    .cfg_cols_i(cfg_cols_i), .cfg_skew_en_i(cfg_skew_en_i), .cfg_ld_i(cfg_ld_i),
    .tile_len_i(tile_len_i), .number_of_columns_o(number_of_columns_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_last_o(out_last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ctl(input string tag, input logic ev, input logic el, input logic edn, input logic erdy);
    chk({tag, ".valid"}, 64'(out_valid_o), 64'(ev));
    chk({tag, ".last"},  64'(out_last_o),  64'(el));
    chk({tag, ".done"},  64'(done_o),      64'(edn));
    chk({tag, ".ready"}, 64'(in_ready_o),  64'(erdy));
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] d0, input logic e);
    in_valid_i = v;
    in_data_i[W-1:0] = d0;
    en_i = e;
    #2;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    out_reg_shift_rst_i = 1'b1;
    en_i = 1'b1; in_valid_i = 1'b0; cfg_ld_i = 1'b0; cfg_cols_i = '0;
    cfg_skew_en_i = 1'b0; tile_len_i = '0;
    in_data_i = 64'h1234_5678_9abc_def0;
    #2;
    ctl("rst", 0, 0, 0, 0);
    chk("rst.busy",  64'(busy_o), 64'd0);
    chk("rst.ncols", 64'(number_of_columns_o), 64'd4);
    chk("rst.data",  out_data_o, 64'h1234_5678_9abc_def0);
    tick();
    out_reg_shift_rst_i = 1'b0;
    in_data_i = '0;

    // A: full array, no skew, L=3 -> zero latency
    tile_len_i = 16'd3;
    cyc(1, 16'd10, 1); ctl("A0", 1, 0, 0, 1); chk("A0.d", 64'(out_data_o[W-1:0]), 64'd10); tick();
    cyc(1, 16'd11, 1); ctl("A1", 1, 0, 0, 1); chk("A1.d", 64'(out_data_o[W-1:0]), 64'd11); tick();
    cyc(1, 16'd12, 1); ctl("A2", 1, 1, 0, 1); chk("A2.d", 64'(out_data_o[W-1:0]), 64'd12); tick();
    cyc(0, 16'd0, 1);  ctl("A3", 0, 0, 1, 0); chk("A3.busy", 64'(busy_o), 64'd1); tick();
    cyc(0, 16'd0, 1);  ctl("A4", 0, 0, 0, 1); chk("A4.busy", 64'(busy_o), 64'd0);
    cfg_ld_i = 1'b1; cfg_cols_i = 3'd2; cfg_skew_en_i = 1'b1;
    tick();
    cfg_ld_i = 1'b0;
    chk("B.ncols", 64'(number_of_columns_o), 64'd2);

    // B: cols=2, skew on -> D={5,4,3,2}; wavefront 100+c at cycle c realigns at cycle 5
    tile_len_i = 16'd1;
    cyc(1, 16'd100, 1); ctl("B0", 0, 0, 0, 1); tick();
    in_data_i[31:16] = 16'd101;
    cfg_ld_i = 1'b1; cfg_cols_i = 3'd3; cfg_skew_en_i = 1'b0;
    cyc(0, 16'd0, 1); ctl("B1", 0, 0, 0, 0); chk("B1.busy", 64'(busy_o), 64'd1); tick();
    cfg_ld_i = 1'b0;
    chk("B.busyld", 64'(number_of_columns_o), 64'd2);
    in_data_i[31:16] = '0; in_data_i[47:32] = 16'd102;
    cyc(0, 16'd0, 1); ctl("B2", 0, 0, 0, 0); tick();
    in_data_i[47:32] = '0; in_data_i[63:48] = 16'd103;
    cyc(0, 16'd0, 1); ctl("B3", 0, 0, 0, 0); tick();
    in_data_i[63:48] = '0;
    cyc(0, 16'd0, 1); ctl("B4", 0, 0, 0, 0); tick();
    cyc(0, 16'd0, 1); ctl("B5", 1, 1, 0, 0);
    chk("B5.data", out_data_o, {16'd103, 16'd102, 16'd101, 16'd100}); tick();
    cyc(0, 16'd0, 1); ctl("B6", 0, 0, 1, 0); tick();
    cyc(0, 16'd0, 1); ctl("B7", 0, 0, 0, 1);
    cfg_ld_i = 1'b1; cfg_cols_i = 3'd3; cfg_skew_en_i = 1'b0;
    tick();
    cfg_ld_i = 1'b0;
    chk("C.ncols", 64'(number_of_columns_o), 64'd3);

    // C: cols=3 (D=1), L=4, two stalled cycles in DRAIN
    tile_len_i = 16'd4;
    cyc(1, 16'd20, 1); ctl("C0", 0, 0, 0, 1); tick();
    cyc(1, 16'd21, 1); ctl("C1", 1, 0, 0, 1); chk("C1.d", 64'(out_data_o[W-1:0]), 64'd20); tick();
    cyc(1, 16'd22, 1); ctl("C2", 1, 0, 0, 1); chk("C2.d", 64'(out_data_o[W-1:0]), 64'd21); tick();
    cyc(1, 16'd23, 1); ctl("C3", 1, 0, 0, 1); chk("C3.d", 64'(out_data_o[W-1:0]), 64'd22); tick();
    cyc(0, 16'd0, 0);  ctl("C4", 0, 0, 0, 0); chk("C4.d", 64'(out_data_o[W-1:0]), 64'd23); tick();
    cyc(0, 16'd0, 0);  ctl("C5", 0, 0, 0, 0); chk("C5.d", 64'(out_data_o[W-1:0]), 64'd23); tick();
    cyc(0, 16'd0, 1);  ctl("C6", 1, 1, 0, 0); chk("C6.d", 64'(out_data_o[W-1:0]), 64'd23); tick();
    cyc(0, 16'd0, 1);  ctl("C7", 0, 0, 1, 0); tick();
    cyc(0, 16'd0, 1);  ctl("C8", 0, 0, 0, 1);

    // E: tile_len=0 behaves as a single-beat tile
    tile_len_i = 16'd0;
    cyc(1, 16'd55, 1); ctl("E0", 0, 0, 0, 1); tick();
    cyc(0, 16'd0, 1);  ctl("E1", 1, 1, 0, 0); chk("E1.d", 64'(out_data_o[W-1:0]), 64'd55); tick();
    cyc(0, 16'd0, 1);  ctl("E2", 0, 0, 1, 0); tick();
    cyc(0, 16'd0, 1);  ctl("E3", 0, 0, 0, 1);
    cfg_ld_i = 1'b1; cfg_cols_i = 3'd0;
    tick();
    cfg_ld_i = 1'b0;
    chk("E.cols0", 64'(number_of_columns_o), 64'd4);
    cyc(0, 16'h0abc, 1); chk("E.pass", 64'(out_data_o[W-1:0]), 64'h0abc);

    // F: reset asserted while draining
    cfg_ld_i = 1'b1; cfg_cols_i = 3'd2;
    tick();
    cfg_ld_i = 1'b0;
    tile_len_i = 16'd1;
    cyc(1, 16'd77, 1); ctl("F0", 0, 0, 0, 1); tick();
    cyc(0, 16'd0, 1);  ctl("F1", 0, 0, 0, 0); chk("F1.busy", 64'(busy_o), 64'd1);
    #1 out_reg_shift_rst_i = 1'b1;
    #1;
    chk("F.busy",  64'(busy_o), 64'd0);
    chk("F.valid", 64'(out_valid_o), 64'd0);
    chk("F.ncols", 64'(number_of_columns_o), 64'd4);
    chk("F.ready", 64'(in_ready_o), 64'd0);
    tick();
    out_reg_shift_rst_i = 1'b0;
    #2; ctl("F2", 0, 0, 0, 1); tick();
    #2; ctl("F3", 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
